// File: rtl/gf_inv_seq.sv
// ---------------------------------------------------------------------------
// gf_inv_seq
//
// Sequential GF(2^8) multiplicative inverse for the AES S-box path.
// Computes inv(x) = x^254 modulo x^8+x^4+x^3+x+1 by square-and-multiply,
// reusing a single combinational multiplier (garoa_Cal) once per cycle.
// One operand is in flight at a time.
//
// Parameters:
//   ZERO_FAST : 1 = operand 0x00 bypasses the loop and completes at once,
//               0 = operand 0x00 runs the whole loop (result is still 0x00)
//   CNT_W     : iteration counter width, must be at least 3
//
// Ports:
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : operand valid
//   in_ready   : engine can accept an operand (IDLE only)
//   in_data    : operand x
//   out_valid  : result valid (DONE state)
//   out_ready  : downstream accepts the result
//   out_data   : x^254, 0x00 for x = 0x00
//   busy       : high while in SQ, MUL or DONE
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// garoa_Cal
//
// Combinational GF(2^8) multiplier, d = x * y modulo x^8+x^4+x^3+x+1.
//
// Ports:
//   x, y : operands
//   d    : product
// ---------------------------------------------------------------------------
module garoa_Cal (
    input  logic [7:0] x,
    input  logic [7:0] y,
    output logic [7:0] d
);

    logic [7:0] shifted;
    logic [7:0] acc;

    // Shift-and-add: walk the bits of y, accumulating successive xtime()
    // multiples of x, reducing by 0x1B whenever bit 7 falls off.
    always_comb begin
        acc     = 8'h00;
        shifted = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) begin
                acc = acc ^ shifted;
            end
            shifted = {shifted[6:0], 1'b0} ^ (shifted[7] ? 8'h1B : 8'h00);
        end
        d = acc;
    end

endmodule

module gf_inv_seq #(
    parameter int ZERO_FAST = 1,
    parameter int CNT_W     = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQ   = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;

    // The last MUL step is the seventh one, counted from zero.
    localparam logic [CNT_W-1:0] K_LAST = CNT_W'(6);

    state_t           state;
    state_t           state_nxt;
    logic [7:0]       s;
    logic [7:0]       s_nxt;
    logic [7:0]       r;
    logic [7:0]       r_nxt;
    logic [CNT_W-1:0] k;
    logic [CNT_W-1:0] k_nxt;
    logic             started;
    logic             accept;
    logic             zero_skip;
    logic [7:0]       mul_x;
    logic [7:0]       mul_y;
    logic [7:0]       mul_d;

    garoa_Cal u_mul (
        .x (mul_x),
        .y (mul_y),
        .d (mul_d)
    );

    // in_ready must stay low while reset is held and rise only after the
    // first clock edge that follows release, so a one-shot flag gates it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started <= 1'b0;
        end else begin
            started <= 1'b1;
        end
    end

    assign in_ready  = (state == IDLE) && started;
    assign accept    = in_valid && in_ready;
    assign zero_skip = (ZERO_FAST != 0) && (in_data == 8'h00);

    // State and datapath registers. r doubles as the result register, so
    // out_data never comes straight from the multiplier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            s     <= 8'h00;
            r     <= 8'h00;
            k     <= '0;
        end else begin
            state <= state_nxt;
            s     <= s_nxt;
            r     <= r_nxt;
            k     <= k_nxt;
        end
    end

    // Next-state logic and multiplier operand selection. SQ squares the
    // running power s; MUL folds it into the accumulator r. After seven
    // pairs r holds x^(2+4+...+128) = x^254.
    always_comb begin
        state_nxt = state;
        s_nxt     = s;
        r_nxt     = r;
        k_nxt     = k;
        mul_x     = 8'h00;
        mul_y     = 8'h00;
        case (state)
            IDLE: begin
                if (accept) begin
                    s_nxt = in_data;
                    k_nxt = '0;
                    if (zero_skip) begin
                        r_nxt     = 8'h00;
                        state_nxt = DONE;
                    end else begin
                        r_nxt     = 8'h01;
                        state_nxt = SQ;
                    end
                end
            end
            SQ: begin
                mul_x     = s;
                mul_y     = s;
                s_nxt     = mul_d;
                state_nxt = MUL;
            end
            MUL: begin
                mul_x = r;
                mul_y = s;
                r_nxt = mul_d;
                k_nxt = k + 1'b1;
                if (k == K_LAST) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = SQ;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs decode the registered state, so reset clears them at once.
    assign out_valid = (state == DONE);
    assign out_data  = r;
    assign busy      = (state != IDLE);

endmodule
